// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: command sequencer that drives a 4-bit counter.
// Commands (NOP/LOAD/RUN/WAIT) are queued in a small FIFO and executed in order.
// Every drive output is registered from the next-state decode, so each output
// reflects the state the FSM is currently in.
module counter_cmd_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int ARG_W      = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        flush_i,
   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic [1:0]                  cmd_op_i,
   input  logic [ARG_W-1:0]            cmd_arg_i,
   output logic                        enable_o,
   output logic                        load_o,
   output logic [3:0]                  data_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = ARG_W + 2;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_NOP  = 3'd4;

   logic [FIFO_DEPTH-1:0][EW-1:0] mem_flat;
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]    level_reg, level_next;
   logic [2:0]       state_reg, state_next;
   logic [ARG_W-1:0] cnt_reg, cnt_next;
   logic             enable_reg, load_reg, busy_reg, done_reg;
   logic             enable_next, load_next, busy_next, done_next;
   logic [3:0]       data_reg, data_next;
   logic             push, pop, last_cycle, can_pop, fifo_empty;
   logic [1:0]       head_op;
   logic [ARG_W-1:0] head_arg;

   // Full exactly when the level's top bit is set (level == FIFO_DEPTH), so
   // ready never depends on a same-cycle pop.
   assign cmd_ready_o = ~level_reg[AW];
   assign fifo_empty  = (level_reg == '0);
   assign push        = cmd_valid_i & cmd_ready_o & ~flush_i;
   assign {head_op, head_arg} = mem_flat[rd_ptr_reg];

   // One storage register per FIFO entry, written when the write pointer selects it.
   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [EW-1:0] entry_reg;
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i)
               entry_reg <= '0;
            else if (push && (wr_ptr_reg == AW'(gi)))
               entry_reg <= {cmd_op_i, cmd_arg_i};
         end
         assign mem_flat[gi] = entry_reg;
      end
   endgenerate

   // Final cycle of the command in progress; a new command may be popped on it.
   always_comb begin
      last_cycle = 1'b0;
      case (state_reg)
         ST_LOAD, ST_NOP: last_cycle = 1'b1;
         ST_RUN, ST_WAIT: last_cycle = (cnt_reg <= ARG_W'(1));
         default:         last_cycle = 1'b0;
      endcase
   end

   assign can_pop    = (state_reg == ST_IDLE) | last_cycle;
   assign pop        = can_pop & ~fifo_empty & ~flush_i;
   assign level_next = flush_i ? '0 : (level_reg + LW'(push) - LW'(pop));

   // Next-state and count decode; flush overrides everything and returns to idle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (flush_i) begin
         state_next = ST_IDLE;
      end else if (can_pop) begin
         if (!fifo_empty) begin
            cnt_next = head_arg;
            case (head_op)
               2'b01:   state_next = ST_LOAD;
               2'b10:   state_next = ST_RUN;
               2'b11:   state_next = ST_WAIT;
               default: state_next = ST_NOP;
            endcase
         end else begin
            state_next = ST_IDLE;
         end
      end else begin
         cnt_next = cnt_reg - ARG_W'(1);
      end
   end

   // Output values for the state being entered; RUN with a zero count never enables.
   always_comb begin
      enable_next = (state_next == ST_RUN) && (cnt_next != '0);
      load_next   = (state_next == ST_LOAD);
      busy_next   = (state_next != ST_IDLE);
      data_next   = load_next ? cnt_next[3:0] : data_reg;
      case (state_next)
         ST_LOAD, ST_NOP: done_next = 1'b1;
         ST_RUN, ST_WAIT: done_next = (cnt_next <= ARG_W'(1));
         default:         done_next = 1'b0;
      endcase
   end

   // FIFO pointers, FSM state and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         enable_reg <= 1'b0;
         load_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         data_reg   <= '0;
      end else begin
         if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         level_reg  <= level_next;
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         enable_reg <= enable_next;
         load_reg   <= load_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
         data_reg   <= data_next;
      end
   end

   assign enable_o = enable_reg;
   assign load_o   = load_reg;
   assign data_o   = data_reg;
   assign busy_o   = busy_reg;
   assign done_o   = done_reg;
   assign level_o  = level_reg;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Testbench for counter_cmd_seq: scoreboard of expected per-cycle outputs built
// at push time, consumed by a monitor whenever the DUT reports busy.
module tb_counter_cmd_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       flush = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_arg = 8'h00;
   logic       cmd_ready, enable, load, busy, done;
   logic [3:0] data;
   logic [2:0] level;

   typedef struct packed {
      logic       en;
      logic       ld;
      logic [3:0] d;
      logic       dn;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;
   int busy_cycles = 0, en_count = 0, done_count = 0;
   int cyc = 0, first_busy = 0, last_busy = 0;
   logic [3:0] model_data = 4'h0;
   logic [3:0] ds_cnt;

   counter_cmd_seq #(.FIFO_DEPTH(4), .ARG_W(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg),
      .enable_o(enable), .load_o(load), .data_o(data),
      .busy_o(busy), .done_o(done), .level_o(level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream 4-bit counter driven by the sequencer outputs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ds_cnt <= 4'h0;
      else if (load)   ds_cnt <= data;
      else if (enable) ds_cnt <= ds_cnt + 4'd1;
   end

   // Monitor: each busy cycle consumes one expected entry; idle cycles must be quiet.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (busy) begin
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_busy cyc=%0d: busy_o=1 with nothing pending", cyc);
            end else begin
               mon_e = sb.pop_front();
               if ({enable, load, data, done} !== mon_e) begin
                  errors++;
                  $display("FAIL cycle_outputs cyc=%0d: {en,ld,data,done} got %b required %b",
                           cyc, {enable, load, data, done}, mon_e);
               end
            end
            if (busy_cycles == 0) first_busy = cyc;
            last_busy = cyc;
            busy_cycles++;
            if (enable) en_count++;
            if (done)   done_count++;
         end else if ({enable, load, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d: {en,ld,done} got %b required 000",
                     cyc, {enable, load, done});
         end
      end
   end

   task automatic reset_stats();
      busy_cycles = 0;
      en_count    = 0;
      done_count  = 0;
   endtask

   // Expected per-cycle trace of one command, appended when it is accepted.
   task automatic add_expected(input logic [1:0] op, input logic [7:0] arg);
      int n;
      n = (arg == 8'd0) ? 1 : int'(arg);
      case (op)
         2'b01: begin
            model_data = arg[3:0];
            sb.push_back({1'b0, 1'b1, arg[3:0], 1'b1});
         end
         2'b10: begin
            for (int i = 0; i < n; i++)
               sb.push_back({(arg != 8'd0), 1'b0, model_data, (i == n - 1)});
         end
         2'b11: begin
            for (int i = 0; i < n; i++)
               sb.push_back({1'b0, 1'b0, model_data, (i == n - 1)});
         end
         default: sb.push_back({1'b0, 1'b0, model_data, 1'b1});
      endcase
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [7:0] arg);
      int t = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      while (!cmd_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: cmd_ready_o=0 after %0d cycles, required 1", t);
         cmd_valid = 1'b0;
      end else begin
         add_expected(op, arg);
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      do begin
         @(negedge clk);
         #1;
         t++;
      end while ((busy || sb.size() != 0) && t < 600);
      checks++;
      if (busy || sb.size() != 0) begin
         errors++;
         $display("FAIL %s_idle_timeout: busy_o=%b pending=%0d, required 0 and 0", name, busy, sb.size());
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({enable, load, data, busy, done} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: {en,ld,data,busy,done} got %b required 0", {enable, load, data, busy, done});
      end
      checks++;
      if (level !== 3'd0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_fifo: level=%0d ready=%b required 0 and 1", level, cmd_ready);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || level !== 3'd0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset: busy=%b level=%0d ready=%b required 0 0 1", busy, level, cmd_ready);
      end
   endtask

   task automatic test_load();
      reset_stats();
      push_cmd(2'b01, 8'h09);
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || load !== 1'b0) begin
         errors++;
         $display("FAIL load_latency_early: busy=%b load=%b one edge after accept, required 0 0", busy, load);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({load, data, done, busy} !== {1'b1, 4'h9, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL load_active: {ld,data,done,busy} got %b required 11001 11", {load, data, done, busy});
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || load !== 1'b0 || data !== 4'h9) begin
         errors++;
         $display("FAIL load_after: busy=%b load=%b data=%h required 0 0 9", busy, load, data);
      end
      wait_idle("load");
   endtask

   task automatic test_back_to_back();
      reset_stats();
      push_cmd(2'b01, 8'h03);
      push_cmd(2'b10, 8'd5);
      push_cmd(2'b11, 8'd2);
      push_cmd(2'b10, 8'd0);
      wait_idle("b2b");
      checks++;
      if (done_count != 4 || en_count != 5) begin
         errors++;
         $display("FAIL b2b_counts: done=%0d enable=%0d required 4 5", done_count, en_count);
      end
      checks++;
      if (busy_cycles != 9 || (last_busy - first_busy + 1) != 9) begin
         errors++;
         $display("FAIL b2b_contiguous: busy=%0d span=%0d required 9 9", busy_cycles, last_busy - first_busy + 1);
      end
      checks++;
      if (ds_cnt !== 4'd8) begin
         errors++;
         $display("FAIL b2b_counter: got %0d required 8", ds_cnt);
      end
   endtask

   task automatic test_full();
      reset_stats();
      push_cmd(2'b10, 8'd200);
      for (int i = 0; i < 4; i++) push_cmd(2'b11, 8'd1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_arg   = 8'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (cmd_ready !== 1'b0 || level !== 3'd4) begin
            errors++;
            $display("FAIL full_hold: ready=%b level=%0d required 0 4", cmd_ready, level);
         end
      end
      push_cmd(2'b11, 8'd1);
      checks++;
      if (busy_cycles < 200) begin
         errors++;
         $display("FAIL full_early_accept: accepted after %0d busy cycles, required >=200", busy_cycles);
      end
      wait_idle("full");
      checks++;
      if (en_count != 200 || done_count != 6) begin
         errors++;
         $display("FAIL full_counts: enable=%0d done=%0d required 200 6", en_count, done_count);
      end
   endtask

   task automatic test_flush();
      logic [3:0] saved;
      int t = 0;
      saved = model_data;
      reset_stats();
      push_cmd(2'b10, 8'd10);
      push_cmd(2'b11, 8'd3);
      push_cmd(2'b10, 8'd2);
      while (en_count < 3 && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_arg   = 8'h0F;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({enable, load, busy, done} !== 4'b0000 || level !== 3'd0) begin
         errors++;
         $display("FAIL flush_outputs: {en,ld,busy,done}=%b level=%0d required 0000 0", {enable, load, busy, done}, level);
      end
      checks++;
      if (data !== saved) begin
         errors++;
         $display("FAIL flush_data: got %h required %h", data, saved);
      end
      sb.delete();
      model_data = saved;
      repeat (15) @(negedge clk);
      #1;
      checks++;
      if (en_count != 3 || done_count != 0 || level !== 3'd0) begin
         errors++;
         $display("FAIL flush_after: enable=%0d done=%0d level=%0d required 3 0 0", en_count, done_count, level);
      end
   endtask

   task automatic test_async_reset();
      int t = 0;
      reset_stats();
      push_cmd(2'b10, 8'd20);
      push_cmd(2'b11, 8'd5);
      while (en_count < 2 && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({enable, busy, done, load} !== 4'b0000 || level !== 3'd0 || data !== 4'h0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: {en,busy,done,ld}=%b level=%0d data=%h ready=%b required 0000 0 0 1",
                  {enable, busy, done, load}, level, data, cmd_ready);
      end
      sb.delete();
      model_data = 4'h0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      reset_stats();
      push_cmd(2'b01, 8'h05);
      push_cmd(2'b10, 8'd3);
      wait_idle("rst_recover");
      checks++;
      if (en_count != 3 || ds_cnt !== 4'd8) begin
         errors++;
         $display("FAIL rst_recover: enable=%0d counter=%0d required 3 8", en_count, ds_cnt);
      end
   endtask

   task automatic test_run255();
      logic [3:0] start;
      logic [3:0] expc;
      start = ds_cnt;
      expc  = start + 4'hF;
      reset_stats();
      push_cmd(2'b10, 8'd255);
      wait_idle("run255");
      checks++;
      if (en_count != 255 || done_count != 1) begin
         errors++;
         $display("FAIL run255_counts: enable=%0d done=%0d required 255 1", en_count, done_count);
      end
      checks++;
      if (ds_cnt !== expc) begin
         errors++;
         $display("FAIL run255_counter: got %0d required %0d", ds_cnt, expc);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_full();
      test_flush();
      test_async_reset();
      test_run255();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
